pri_cpi_monitor: RTL and testbench
==================================

PRI_CPI_MONITOR -- requirements
Module: pri_cpi_monitor

Interface
REQ-001 SHALL have parameter PRI_TOL, default 2, meaning the allowed |measured - expected| PRI period error in clocks.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port i_Enable, input, 1 bit, monitor enable.
REQ-005 SHALL have port i_PRI_p, input, 1 bit, single-cycle PRI start pulse.
REQ-006 SHALL have port i_CPI_p, input, 1 bit, single-cycle CPI start pulse; it also marks a PRI start.
REQ-007 SHALL have port i_PRI_Width, input, 16 bits, expected PRI period in clocks.
REQ-008 SHALL have port i_CPI_Width, input, 16 bits, expected PRIs per CPI.
REQ-009 SHALL have port i_Waveform_Type, input, 3 bits, waveform code.
REQ-010 SHALL have port i_Err_Clr, input, 1 bit, which clears the sticky error flags.
REQ-011 SHALL have port o_PRI_Period, output, 16 bits, last measured PRI period.
REQ-012 SHALL have port o_PRI_Valid, output, 1 bit, one-cycle strobe when o_PRI_Period updates.
REQ-013 SHALL have port o_PRI_Index, output, 16 bits, index of the current PRI within the CPI (0-based).
REQ-014 SHALL have port o_First_PRI, output, 1 bit, high while o_PRI_Index==0 in IN_CPI.
REQ-015 SHALL have port o_CPI_Done, output, 1 bit, one-cycle strobe at CPI end.
REQ-016 SHALL have port o_SRIO_Mem_Sel, output, 1 bit, ping-pong buffer select that toggles per completed CPI.
REQ-017 SHALL have port o_Waveform_Type, output, 3 bits, i_Waveform_Type latched at CPI start.
REQ-018 SHALL have ports o_PRI_Err, o_CPI_Err and o_Timeout, outputs, 1 bit each, sticky error flags.

Function
REQ-019 SHALL implement a state machine with states IDLE, WAIT_CPI and IN_CPI.
REQ-020 SHALL move IDLE->WAIT_CPI when i_Enable=1.
REQ-021 SHALL go to IDLE from any state when i_Enable=0, clearing the period counter, o_PRI_Index and o_First_PRI and holding o_SRIO_Mem_Sel.
REQ-022 SHALL, in WAIT_CPI, ignore i_PRI_p.
REQ-023 SHALL, on i_CPI_p in WAIT_CPI, enter IN_CPI, clear the period counter, set o_PRI_Index=0, and latch o_Waveform_Type.
REQ-024 SHALL keep the period counter saturating at 16 bits, cleared to 1 on the cycle after any PRI start and incremented each clock otherwise, so that pulses N clocks apart measure N.
REQ-025 SHALL, on each PRI start in IN_CPI, register o_PRI_Period with the counter value and pulse o_PRI_Valid the next cycle (latency 1).
REQ-026 SHALL set o_PRI_Err when the 17-bit signed difference between o_PRI_Period and i_PRI_Width exceeds PRI_TOL in magnitude.
REQ-027 SHALL, on i_PRI_p alone in IN_CPI, increment o_PRI_Index; if o_PRI_Index+1 >= i_CPI_Width, set o_CPI_Err and saturate o_PRI_Index.
REQ-028 SHALL, on i_CPI_p in IN_CPI, pulse o_CPI_Done, toggle o_SRIO_Mem_Sel, and set o_CPI_Err if o_PRI_Index+1 != i_CPI_Width, then restart the CPI as in REQ-023 in the same cycle.
REQ-029 SHALL treat i_PRI_p and i_CPI_p asserted together as a single CPI start.
REQ-030 SHALL, when the counter saturates at 0xFFFF in IN_CPI, set o_Timeout and return to WAIT_CPI.
REQ-031 SHALL clear all sticky flags on i_Err_Clr, except that a flag being set in the same cycle wins.
REQ-032 SHALL, when i_CPI_Width is 0, treat every CPI as an error and set o_CPI_Err.

Reset
REQ-033 SHALL, on rst, asynchronously enter IDLE and drive every output to 0; the counter and index are 0.
REQ-034 SHALL, when rst is asserted mid-CPI, produce no o_CPI_Done or o_PRI_Valid strobe, and require a fresh i_CPI_p after reset deasserts.

Verification
REQ-035 SHALL be covered by this case: PRI_Width=13000, CPI_Width=50, pulses every 13000 clocks, CPI pulse every 50 PRIs -> o_PRI_Period=13000, index 0..49, o_CPI_Done per CPI, Mem_Sel toggles, no errors.
REQ-036 SHALL be covered by this case: one PRI gap of 13003 (TOL=2) -> o_PRI_Err=1 after it; a gap of 13002 -> no error.
REQ-037 SHALL be covered by this case: 49 or 51 PRIs between CPI pulses -> o_CPI_Err=1; i_Err_Clr clears it.
REQ-038 SHALL be covered by this case: pulses stop for 65535 clocks -> o_Timeout=1, state WAIT_CPI, later PRI pulses ignored until i_CPI_p.
REQ-039 SHALL be covered by this case: PRI pulses before the first CPI pulse -> no o_PRI_Valid; i_PRI_p and i_CPI_p together -> index resets to 0 with o_First_PRI=1.
REQ-040 SHALL be covered by this case: rst and i_Enable=0 asserted mid-CPI -> outputs as REQ-033/REQ-021, Waveform_Type relatched on the next CPI.

Source files
------------

// File: rtl/pri_cpi_monitor.sv
// ---------------------------------------------------------------------------
// pri_cpi_monitor
//   Tracks radar PRI/CPI timing. It measures the clock count between PRI
//   starts, indexes PRIs within a CPI, strobes CPI completion, flips a
//   ping-pong buffer select per completed CPI, and raises sticky error flags
//   for period tolerance violations, wrong PRI counts and lost pulses.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   i_Enable           monitor enable; low forces IDLE
//   i_PRI_p            single-cycle PRI start pulse
//   i_CPI_p            single-cycle CPI start pulse (also a PRI start)
//   i_PRI_Width        expected PRI period in clocks
//   i_CPI_Width        expected PRIs per CPI
//   i_Waveform_Type    waveform code, latched at CPI start
//   i_Err_Clr          clears the sticky error flags
//   o_PRI_Period       last measured PRI period
//   o_PRI_Valid        one-cycle strobe when o_PRI_Period updates
//   o_PRI_Index        0-based index of the current PRI within the CPI
//   o_First_PRI        high while o_PRI_Index==0 inside a CPI
//   o_CPI_Done         one-cycle strobe at CPI end
//   o_SRIO_Mem_Sel     ping-pong buffer select, toggles per completed CPI
//   o_Waveform_Type    waveform code captured at CPI start
//   o_PRI_Err          sticky: measured period outside PRI_TOL
//   o_CPI_Err          sticky: PRI count per CPI wrong
//   o_Timeout          sticky: period counter saturated inside a CPI
// ---------------------------------------------------------------------------
module pri_cpi_monitor #(
  parameter int PRI_TOL = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_Enable,
  input  logic        i_PRI_p,
  input  logic        i_CPI_p,
  input  logic [15:0] i_PRI_Width,
  input  logic [15:0] i_CPI_Width,
  input  logic [2:0]  i_Waveform_Type,
  input  logic        i_Err_Clr,
  output logic [15:0] o_PRI_Period,
  output logic        o_PRI_Valid,
  output logic [15:0] o_PRI_Index,
  output logic        o_First_PRI,
  output logic        o_CPI_Done,
  output logic        o_SRIO_Mem_Sel,
  output logic [2:0]  o_Waveform_Type,
  output logic        o_PRI_Err,
  output logic        o_CPI_Err,
  output logic        o_Timeout
);

  localparam int DATA_W = 16;
  localparam logic signed [DATA_W:0] TOL_S = (DATA_W+1)'(PRI_TOL);

  typedef enum logic [1:0] {IDLE, WAIT_CPI, IN_CPI} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] cnt;
  logic              cpi_start;   // CPI begins (from WAIT_CPI or restart)
  logic              cpi_end;     // CPI pulse while inside a CPI
  logic              pri_only;    // PRI pulse alone inside a CPI
  logic              timeout_ev;
  logic              meas;        // a PRI start that produces a measurement
  logic [DATA_W:0]   idx_inc;
  logic              idx_ovf;
  logic              cpi_mismatch;
  logic              pri_err_set;
  logic              cpi_err_set;

  // Saturating increment of the period counter.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == '1) ? v : v + DATA_W'(1);
  endfunction

  // True when |meas - expv| exceeds the tolerance, using a 17-bit signed
  // difference so the full unsigned range of both operands is representable.
  function automatic logic tol_exceeded(input logic [DATA_W-1:0] meas_v,
                                        input logic [DATA_W-1:0] exp_v);
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] mag;
    diff = $signed({1'b0, meas_v}) - $signed({1'b0, exp_v});
    mag  = diff[DATA_W] ? -diff : diff;
    return mag > TOL_S;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and event decode. A CPI pulse always wins over a coincident
  // PRI pulse, so both together count as a single CPI start.
  always_comb begin
    state_nxt  = state;
    cpi_start  = 1'b0;
    cpi_end    = 1'b0;
    pri_only   = 1'b0;
    timeout_ev = 1'b0;
    if (!i_Enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = WAIT_CPI;
        WAIT_CPI: begin
          if (i_CPI_p) begin
            state_nxt = IN_CPI;
            cpi_start = 1'b1;
          end
        end
        IN_CPI: begin
          if (i_CPI_p) begin
            cpi_end   = 1'b1;
            cpi_start = 1'b1;
          end else if (i_PRI_p) begin
            pri_only  = 1'b1;
          end else if (cnt == '1) begin
            timeout_ev = 1'b1;
            state_nxt  = WAIT_CPI;
          end
        end
        default:  state_nxt = IDLE;
      endcase
    end
  end

  assign meas         = cpi_end | pri_only;
  assign idx_inc      = {1'b0, o_PRI_Index} + (DATA_W+1)'(1);
  assign idx_ovf      = idx_inc >= {1'b0, i_CPI_Width};
  assign cpi_mismatch = idx_inc != {1'b0, i_CPI_Width};
  assign pri_err_set  = meas && tol_exceeded(cnt, i_PRI_Width);
  assign cpi_err_set  = (pri_only && idx_ovf) || (cpi_end && cpi_mismatch);

  assign o_First_PRI  = (state == IN_CPI) && (o_PRI_Index == '0);

  // ---- stage: event decode -> registered counters, strobes and flags ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt             <= '0;
      o_PRI_Period    <= '0;
      o_PRI_Valid     <= 1'b0;
      o_PRI_Index     <= '0;
      o_CPI_Done      <= 1'b0;
      o_SRIO_Mem_Sel  <= 1'b0;
      o_Waveform_Type <= '0;
      o_PRI_Err       <= 1'b0;
      o_CPI_Err       <= 1'b0;
      o_Timeout       <= 1'b0;
    end else begin
      o_PRI_Valid <= meas;
      o_CPI_Done  <= cpi_end;

      if (meas) o_PRI_Period <= cnt;

      // Counter reads 1 the cycle after a start so that N-clock spacing
      // measures N; it only runs inside a CPI.
      if (!i_Enable || state == IDLE)   cnt <= '0;
      else if (cpi_start || pri_only)   cnt <= DATA_W'(1);
      else if (state == IN_CPI)         cnt <= sat_inc(cnt);
      else                              cnt <= '0;

      if (!i_Enable || cpi_start)       o_PRI_Index <= '0;
      else if (pri_only && !idx_ovf)    o_PRI_Index <= idx_inc[DATA_W-1:0];

      if (cpi_end)   o_SRIO_Mem_Sel  <= ~o_SRIO_Mem_Sel;
      if (cpi_start) o_Waveform_Type <= i_Waveform_Type;

      // Sticky flags: a set in the same cycle as a clear wins.
      if (pri_err_set)    o_PRI_Err <= 1'b1;
      else if (i_Err_Clr) o_PRI_Err <= 1'b0;

      if (cpi_err_set)    o_CPI_Err <= 1'b1;
      else if (i_Err_Clr) o_CPI_Err <= 1'b0;

      if (timeout_ev)     o_Timeout <= 1'b1;
      else if (i_Err_Clr) o_Timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pri_cpi_monitor.sv
// Directed bench for pri_cpi_monitor: PRI_Width 20, CPI_Width 4, TOL 2.
module tb_pri_cpi_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_Enable;
  logic        i_PRI_p;
  logic        i_CPI_p;
  logic [15:0] i_PRI_Width;
  logic [15:0] i_CPI_Width;
  logic [2:0]  i_Waveform_Type;
  logic        i_Err_Clr;
  logic [15:0] o_PRI_Period;
  logic        o_PRI_Valid;
  logic [15:0] o_PRI_Index;
  logic        o_First_PRI;
  logic        o_CPI_Done;
  logic        o_SRIO_Mem_Sel;
  logic [2:0]  o_Waveform_Type;
  logic        o_PRI_Err;
  logic        o_CPI_Err;
  logic        o_Timeout;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last     = 0;
  logic exp_mem = 1'b0;

  pri_cpi_monitor #(.PRI_TOL(2)) dut (
    .clk(clk), .rst(rst), .i_Enable(i_Enable), .i_PRI_p(i_PRI_p),
    .i_CPI_p(i_CPI_p), .i_PRI_Width(i_PRI_Width), .i_CPI_Width(i_CPI_Width),
    .i_Waveform_Type(i_Waveform_Type), .i_Err_Clr(i_Err_Clr),
    .o_PRI_Period(o_PRI_Period), .o_PRI_Valid(o_PRI_Valid),
    .o_PRI_Index(o_PRI_Index), .o_First_PRI(o_First_PRI),
    .o_CPI_Done(o_CPI_Done), .o_SRIO_Mem_Sel(o_SRIO_Mem_Sel),
    .o_Waveform_Type(o_Waveform_Type), .o_PRI_Err(o_PRI_Err),
    .o_CPI_Err(o_CPI_Err), .o_Timeout(o_Timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: run did not finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse sampled exactly `gap` clocks after the previous pulse.
  task automatic send(input logic pri, input logic cpi, input int gap);
    while (cyc < last + gap - 1) step(1);
    i_PRI_p = pri;
    i_CPI_p = cpi;
    step(1);
    i_PRI_p = 1'b0;
    i_CPI_p = 1'b0;
    last = cyc;
  endtask

  task automatic err_clear();
    i_Err_Clr = 1'b1;
    step(1);
    i_Err_Clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_Enable = 1'b0; i_PRI_p = 1'b0; i_CPI_p = 1'b0;
    i_PRI_Width = 16'd20; i_CPI_Width = 16'd4; i_Waveform_Type = 3'd0;
    i_Err_Clr = 1'b0;
    step(3);
    // Reset state
    chk("rst_period", o_PRI_Period, 0);
    chk("rst_valid",  o_PRI_Valid, 0);
    chk("rst_index",  o_PRI_Index, 0);
    chk("rst_first",  o_First_PRI, 0);
    chk("rst_done",   o_CPI_Done, 0);
    chk("rst_mem",    o_SRIO_Mem_Sel, 0);
    chk("rst_wave",   o_Waveform_Type, 0);
    chk("rst_errs",   {o_PRI_Err, o_CPI_Err, o_Timeout}, 0);
    rst = 1'b0;
    i_Enable = 1'b1;
    step(3);

    // PRI pulses before the first CPI are ignored
    send(1'b1, 1'b0, 1);
    chk("pre_cpi_valid", o_PRI_Valid, 0);
    send(1'b1, 1'b0, 5);
    chk("pre_cpi_valid2", o_PRI_Valid, 0);
    chk("pre_cpi_first", o_First_PRI, 0);

    // First CPI start
    i_Waveform_Type = 3'd5;
    send(1'b0, 1'b1, 5);
    i_Waveform_Type = 3'd2;
    chk("cpi0_wave",  o_Waveform_Type, 5);
    chk("cpi0_first", o_First_PRI, 1);
    chk("cpi0_index", o_PRI_Index, 0);
    chk("cpi0_valid", o_PRI_Valid, 0);
    chk("cpi0_done",  o_CPI_Done, 0);

    // Two nominal CPIs of 4 PRIs
    for (int c = 0; c < 2; c++) begin
      for (int k = 1; k <= 3; k++) begin
        send(1'b1, 1'b0, 20);
        chk("nom_valid",  o_PRI_Valid, 1);
        chk("nom_period", o_PRI_Period, 20);
        chk("nom_index",  o_PRI_Index, k);
        chk("nom_first",  o_First_PRI, 0);
      end
      send(1'b0, 1'b1, 20);
      exp_mem = ~exp_mem;
      chk("nom_done",   o_CPI_Done, 1);
      chk("nom_mem",    o_SRIO_Mem_Sel, exp_mem);
      chk("nom_index0", o_PRI_Index, 0);
      chk("nom_first1", o_First_PRI, 1);
      chk("nom_errs",   {o_PRI_Err, o_CPI_Err, o_Timeout}, 0);
      chk("nom_wave",   o_Waveform_Type, 2);
      step(1);
      chk("nom_done_clr",  o_CPI_Done, 0);
      chk("nom_valid_clr", o_PRI_Valid, 0);
    end

    // Too few PRIs in a CPI
    send(1'b1, 1'b0, 20);
    send(1'b1, 1'b0, 20);
    send(1'b0, 1'b1, 20);
    exp_mem = ~exp_mem;
    chk("short_cpi_err", o_CPI_Err, 1);
    chk("short_done",    o_CPI_Done, 1);
    err_clear();
    chk("short_clr", o_CPI_Err, 0);

    // Too many PRIs: index saturates at CPI_Width-1
    for (int k = 0; k < 3; k++) send(1'b1, 1'b0, 20);
    chk("long_noerr", o_CPI_Err, 0);
    send(1'b1, 1'b0, 20);
    chk("long_cpi_err", o_CPI_Err, 1);
    chk("long_index",   o_PRI_Index, 3);
    send(1'b0, 1'b1, 20);
    exp_mem = ~exp_mem;
    chk("long_index0",  o_PRI_Index, 0);
    chk("long_mem",     o_SRIO_Mem_Sel, exp_mem);
    err_clear();
    chk("long_clr", o_CPI_Err, 0);

    // PRI tolerance boundaries
    send(1'b1, 1'b0, 23);
    chk("tol_p3_err",    o_PRI_Err, 1);
    chk("tol_p3_period", o_PRI_Period, 23);
    err_clear();
    chk("tol_clr", o_PRI_Err, 0);
    send(1'b1, 1'b0, 22);
    chk("tol_p2_err",    o_PRI_Err, 0);
    chk("tol_p2_period", o_PRI_Period, 22);
    i_Err_Clr = 1'b1;              // set in the same cycle as clear wins
    send(1'b1, 1'b0, 17);
    i_Err_Clr = 1'b0;
    chk("tol_m3_setwins", o_PRI_Err, 1);
    err_clear();
    send(1'b0, 1'b1, 18);
    exp_mem = ~exp_mem;
    chk("tol_m2_err",    o_PRI_Err, 0);
    chk("tol_m2_period", o_PRI_Period, 18);
    chk("tol_cpi_err",   o_CPI_Err, 0);

    // Enable dropped mid-CPI
    send(1'b1, 1'b0, 20);
    chk("en_pre_index", o_PRI_Index, 1);
    i_Enable = 1'b0;
    step(1);
    chk("en_index", o_PRI_Index, 0);
    chk("en_first", o_First_PRI, 0);
    chk("en_mem",   o_SRIO_Mem_Sel, exp_mem);
    chk("en_done",  o_CPI_Done, 0);
    i_Enable = 1'b1;
    step(2);
    send(1'b1, 1'b0, 1);
    chk("en_wait_valid", o_PRI_Valid, 0);
    i_Waveform_Type = 3'd6;
    send(1'b0, 1'b1, 3);
    chk("en_wave",  o_Waveform_Type, 6);
    chk("en_first1", o_First_PRI, 1);
    chk("en_done2", o_CPI_Done, 0);

    // PRI and CPI together: one CPI start
    for (int k = 0; k < 3; k++) send(1'b1, 1'b0, 20);
    send(1'b1, 1'b1, 20);
    exp_mem = ~exp_mem;
    chk("both_done",  o_CPI_Done, 1);
    chk("both_index", o_PRI_Index, 0);
    chk("both_first", o_First_PRI, 1);
    chk("both_err",   o_CPI_Err, 0);
    chk("both_mem",   o_SRIO_Mem_Sel, exp_mem);

    // Asynchronous reset mid-CPI
    send(1'b1, 1'b0, 20);
    rst = 1'b1;
    #1;
    chk("arst_index",  o_PRI_Index, 0);
    chk("arst_period", o_PRI_Period, 0);
    chk("arst_wave",   o_Waveform_Type, 0);
    chk("arst_valid",  o_PRI_Valid, 0);
    step(2);
    chk("arst_strobes", {o_CPI_Done, o_PRI_Valid}, 0);
    chk("arst_mem",     o_SRIO_Mem_Sel, 0);
    rst = 1'b0;
    step(2);
    send(1'b1, 1'b0, 1);
    chk("arst_nofresh_valid", o_PRI_Valid, 0);
    i_Waveform_Type = 3'd3;
    send(1'b0, 1'b1, 3);
    chk("arst_wave2",  o_Waveform_Type, 3);
    chk("arst_first",  o_First_PRI, 1);

    // CPI width of zero is always an error
    i_CPI_Width = 16'd0;
    send(1'b1, 1'b0, 20);
    chk("w0_err",   o_CPI_Err, 1);
    chk("w0_index", o_PRI_Index, 0);
    err_clear();
    i_CPI_Width = 16'd4;

    // Timeout: counter saturates 65535 clocks after the last start
    while (cyc < last + 65534) step(1);
    chk("to_before", o_Timeout, 0);
    chk("to_in_cpi", o_First_PRI, 1);
    step(1);
    chk("to_set",   o_Timeout, 1);
    chk("to_state", o_First_PRI, 0);
    send(1'b1, 1'b0, 5);
    chk("to_pri_ignored", o_PRI_Valid, 0);
    send(1'b0, 1'b1, 5);
    chk("to_cpi_first", o_First_PRI, 1);
    chk("to_cpi_valid", o_PRI_Valid, 0);
    err_clear();
    chk("to_clr", o_Timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
